// File: rtl/imsic_msi_pkg.sv
// imsic_msi_pkg: shared state encoding and message field offsets for the MSI scheduler
package imsic_msi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    // Message layout: {hart_id, intp_file, setipnum}
    localparam int SETIPNUM_LSB  = 0;
    localparam int INTP_FILE_LSB = 5;
    localparam int HART_ID_LSB   = 11;

endpackage

// File: rtl/imsic_msi_fifo.sv
// imsic_msi_fifo: small synchronous FIFO with wrap-bit pointers
module imsic_msi_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra top bit tells full from empty
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/imsic_msi_sched.sv
// imsic_msi_sched: round-robin MSI arbiter, legality filter, FIFO and pulse serialiser.
// Optional counters enabled by defining IMSIC_MSI_SCHED_CNT_EN.
module imsic_msi_sched
    import imsic_msi_pkg::*;
#(
    parameter int NR_REQ         = 3,
    parameter int MSI_INFO_WIDTH = 17,
    parameter int NR_SRC         = 32,
    parameter int NR_SRC_WIDTH   = $clog2(NR_SRC),
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLD_CYC       = 4,
    parameter int GAP_CYC        = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NR_REQ-1:0]                i_req_vld,
    input  logic [NR_REQ*MSI_INFO_WIDTH-1:0] i_req_info,
    output logic [NR_REQ-1:0]                o_req_rdy,
    output logic [MSI_INFO_WIDTH-1:0]        o_msi_info,
    output logic                             o_msi_info_vld,
    output logic                             o_drop,
    output logic                             o_busy
`ifdef IMSIC_MSI_SCHED_CNT_EN
    ,
    output logic [31:0]                      o_msg_cnt,
    output logic [15:0]                      o_drop_cnt
`endif
);

    localparam int PTR_W   = NR_REQ > 1 ? $clog2(NR_REQ) : 1;
    localparam int CNT_MAX = HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_e                    state;
    logic [CNT_W-1:0]          cnt;
    logic [PTR_W-1:0]          rr_ptr;
    logic [PTR_W-1:0]          gnt_idx;
    logic [PTR_W-1:0]          idx;
    logic [MSI_INFO_WIDTH-1:0] req_msg [NR_REQ];
    logic [MSI_INFO_WIDTH-1:0] acc_msg;
    logic [MSI_INFO_WIDTH-1:0] head;
    logic [NR_SRC_WIDTH-1:0]   sip;
    logic                      acc;
    logic                      legal;
    logic                      pop;
    logic                      full;
    logic                      empty;

    for (genvar g = 0; g < NR_REQ; g++) begin : g_msg
        assign req_msg[g] = i_req_info[g*MSI_INFO_WIDTH +: MSI_INFO_WIDTH];
    end

    // Round-robin search from rr_ptr; descending loop so the nearest requester wins
    always_comb begin
        gnt_idx = rr_ptr;
        idx     = rr_ptr;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NR_REQ);
            if (i_req_vld[idx]) gnt_idx = idx;
        end
    end

    assign o_req_rdy = (rstn && !full && |i_req_vld) ? NR_REQ'(1) << gnt_idx : '0;
    assign acc       = |(o_req_rdy & i_req_vld);
    assign acc_msg   = req_msg[gnt_idx];
    assign sip       = acc_msg[SETIPNUM_LSB +: NR_SRC_WIDTH];
    assign legal     = sip != '0 && {1'b0, sip} < (NR_SRC_WIDTH+1)'(NR_SRC);
    assign pop       = state == IDLE && !empty;
    assign o_busy    = !empty || state != IDLE;

    imsic_msi_fifo #(
        .WIDTH(MSI_INFO_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (acc && legal),
        .din  (acc_msg),
        .pop  (pop),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    // Pointer moves past the granted requester only when a handshake completes
    always_ff @(posedge clk) begin
        if (!rstn) rr_ptr <= '0;
        else if (acc) rr_ptr <= gnt_idx == PTR_W'(NR_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Delivery pulse: HOLD_CYC high, GAP_CYC low with info held for the gate's falling-edge sample
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            cnt            <= '0;
            o_msi_info     <= '0;
            o_msi_info_vld <= 1'b0;
            o_drop         <= 1'b0;
        end else begin
            o_drop <= acc && !legal;
            case (state)
                IDLE: if (!empty) begin
                    o_msi_info     <= head;
                    o_msi_info_vld <= 1'b1;
                    cnt            <= CNT_W'(HOLD_CYC - 1);
                    state          <= HIGH;
                end
                HIGH: if (cnt == '0) begin
                    o_msi_info_vld <= 1'b0;
                    cnt            <= CNT_W'(GAP_CYC - 1);
                    state          <= LOW;
                end else cnt <= cnt - 1'b1;
                LOW: if (cnt == '0) state <= IDLE;
                else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMSIC_MSI_SCHED_CNT_EN
    // Delivered-message counter wraps; drop counter saturates
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_msg_cnt  <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (pop) o_msg_cnt <= o_msg_cnt + 1'b1;
            if (o_drop && ~&o_drop_cnt) o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end
`endif

endmodule
